// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared definitions for the multiply/divide unit: md_op
//                operation codes, FSM state encoding, counter width and
//                default latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Operation class presented by the EX-stage control alongside start.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    // IDLE <=> counter is zero, RUN <=> counter is non-zero.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Busy counter width; latencies must not exceed 2**MD_CNT_W - 1.
    localparam int MD_CNT_W        = 4;
    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

endpackage : md_pkg
`default_nettype wire

// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div
//  Description : MIPS EX-stage multiply/divide unit with HI/LO registers.
//                Results are computed behaviourally at the start edge,
//                held in staging registers, and committed to HI/LO when
//                the fixed-latency busy counter expires.
//
//  Ports       : clk        in   sole clock, rising edge
//                reset      in   asynchronous, active-low
//                start      in   one-cycle operation request
//                md_op[2:0] in   operation class (see md_pkg::md_op_e)
//                a[31:0]    in   rs operand
//                b[31:0]    in   rt operand
//                busy       out  registered, operation in flight
//                stall_req  out  combinational hazard request
//                hi[31:0]   out  registered HI
//                lo[31:0]   out  registered LO
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MD_CNT_W-1:0] c_MULT_LAT = MD_CNT_W'(MULT_LAT);
    localparam logic [MD_CNT_W-1:0] c_DIV_LAT  = MD_CNT_W'(DIV_LAT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]         hi_q,    hi_d;
    logic [31:0]         lo_q,    lo_d;
    logic [31:0]         stg_hi_q, stg_hi_d;
    logic [31:0]         stg_lo_q, stg_lo_d;
    // Cleared for a divide by zero so completion leaves HI/LO untouched.
    logic                stg_wr_q, stg_wr_d;

    md_op_e w_op;
    assign w_op = md_op_e'(md_op);

    // ------------------------------------------------------------------
    // Arithmetic evaluated on the live operands; only consumed at the
    // accepting edge, so later operand changes cannot leak in.
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned
    // product equal to the signed product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide done on magnitudes; this keeps 0x80000000 / -1
    // well defined (magnitude 2^31 fits unsigned, signs cancel).
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_div_signed = (w_op == MD_DIV);
    assign w_a_neg      = w_div_signed & a[31];
    assign w_b_neg      = w_div_signed & b[31];
    assign w_b_zero     = (b == 32'd0);
    assign w_a_mag      = w_a_neg ? (~a + 32'd1) : a;
    assign w_b_mag      = w_b_neg ? (~b + 32'd1) : b;
    // Denominator forced to 1 on b == 0; the result is discarded anyway.
    assign w_b_den      = w_b_zero ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_den;
    assign w_r_mag      = w_a_mag % w_b_den;
    // Quotient truncates toward zero; remainder follows dividend sign.
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stg_hi_d = stg_hi_q;
        stg_lo_d = stg_lo_q;
        stg_wr_d = stg_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (w_op)
                        MD_MULT: begin
                            stg_hi_d = w_prod_s[63:32];
                            stg_lo_d = w_prod_s[31:0];
                            stg_wr_d = 1'b1;
                            cnt_d    = c_MULT_LAT;
                            state_d  = ST_RUN;
                        end
                        MD_MULTU: begin
                            stg_hi_d = w_prod_u[63:32];
                            stg_lo_d = w_prod_u[31:0];
                            stg_wr_d = 1'b1;
                            cnt_d    = c_MULT_LAT;
                            state_d  = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            stg_hi_d = w_rem;
                            stg_lo_d = w_quot;
                            stg_wr_d = ~w_b_zero;
                            cnt_d    = c_DIV_LAT;
                            state_d  = ST_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // start is ignored here; the hazard unit should hold it off.
                cnt_d = cnt_q - {{(MD_CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(MD_CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_IDLE;
                    if (stg_wr_q) begin
                        hi_d = stg_hi_q;
                        lo_d = stg_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            stg_hi_q <= 32'd0;
            stg_lo_q <= 32'd0;
            stg_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            stg_hi_q <= stg_hi_d;
            stg_lo_q <= stg_lo_d;
            stg_wr_q <= stg_wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state_q == ST_RUN);
    assign hi        = hi_q;
    assign lo        = lo_q;
    // Any MD class op (codes 0..3) must wait while the unit is occupied.
    assign stall_req = busy | (start & (md_op <= 3'd3));

endmodule : mult_div
`default_nettype wire

// File: tb/tb_mult_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div
//  Description : Self-checking bench for mult_div. A driver issues directed
//                and random operations, predicts HI/LO from plain 64-bit
//                arithmetic and queues the expectations; a monitor pops
//                them when the unit completes or an MTHI/MTLO lands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div;
    import md_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mult_div #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          due;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];

    // Driver-side model: architectural HI/LO after all accepted ops, and
    // the first edge at which a new start can be accepted.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_free = 0;

    // Monitor-side view of the HI/LO values that should currently be visible.
    logic [31:0] mon_hi = 32'd0;
    logic [31:0] mon_lo = 32'd0;
    logic        prev_busy = 1'b0;
    int          run_len = 0;
    exp_t        mr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] h_in, input logic [31:0] l_in,
                                   output logic [31:0] h, output logic [31:0] l);
        longint          sx, sy, sp, sq, sr;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h  = h_in;
        l  = l_in;
        case (op)
            3'd0: begin sp = sx * sy; h = sp[63:32]; l = sp[31:0]; end
            3'd1: begin up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0]; end
            3'd2: if (y != 0) begin sq = sx / sy; sr = sx % sy; l = sq[31:0]; h = sr[31:0]; end
            3'd3: if (y != 0) begin l = x / y; h = x % y; end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t r;
        int   e;
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        e     = cyc + 1;
        #1 chk("stall_req", stall_req, ((e < m_free) || (op <= 3'd3)));
        if ((e >= m_free) && (op <= 3'd5)) begin
            ref_op(op, x, y, m_hi, m_lo, m_hi, m_lo);
            r.lat = (op <= 3'd1) ? ML : ((op <= 3'd3) ? DL : 0);
            r.due = e + r.lat;
            r.hi  = m_hi;
            r.lo  = m_lo;
            q.push_back(r);
            if (r.lat > 0) m_free = r.due + 1;
        end
    endtask

    // Idle cycles scramble operands and md_op to show they are not re-sampled.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            md_op = 3'($urandom);
            a     = $urandom;
            b     = $urandom;
            #1 chk("stall_idle", stall_req, (cyc + 1 < m_free));
        end
    endtask

    // Returns so that the next drive() lands on the first free edge.
    task automatic wait_free();
        while (cyc + 2 < m_free) idle(1);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            if (busy === 1'b1) run_len++;
            if (prev_busy && (busy === 1'b0)) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: busy fell with nothing pending at cycle %0d", cyc);
                end else begin
                    mr = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mr.due));
                    chk("busy_len", 64'(run_len), 64'(mr.lat));
                    chk("hi_done", hi, mr.hi);
                    chk("lo_done", lo, mr.lo);
                    mon_hi = mr.hi;
                    mon_lo = mr.lo;
                end
                run_len = 0;
            end else if ((q.size() != 0) && (q[0].lat == 0) && (q[0].due == cyc)) begin
                mr = q.pop_front();
                chk("hi_mt", hi, mr.hi);
                chk("lo_mt", lo, mr.lo);
                mon_hi = mr.hi;
                mon_lo = mr.lo;
            end else begin
                chk("hi_hold", hi, mon_hi);
                chk("lo_hold", lo, mon_lo);
            end
            if ((q.size() != 0) && (cyc > q[0].due + 1)) begin
                total++;
                bad++;
                $display("FAIL timeout: result due at cycle %0d not seen by cycle %0d", q[0].due, cyc);
                void'(q.pop_front());
                run_len = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [2:0]  op;
        logic [31:0] x, y;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;

        // Directed cases
        drive(MD_MULT,  32'hFFFF_FFFE, 32'd3);  wait_free();
        drive(MD_MULTU, 32'hFFFF_FFFE, 32'd3);  wait_free();
        drive(MD_DIV,   32'hFFFF_FFF9, 32'd2);  wait_free();
        drive(MD_DIVU,  32'd7,         32'd2);  wait_free();
        drive(MD_MTHI,  32'h0000_1234, 32'd0);
        drive(MD_MTLO,  32'h0000_5678, 32'd0);
        drive(MD_DIVU,  32'd7,         32'd0);  wait_free();
        drive(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_free();

        // Start while busy is ignored; back-to-back issue at the free edge
        drive(MD_MULT,  32'd12345,     32'd6789);
        idle(1);
        drive(MD_MTLO,  32'h0000_DEAD, 32'd0);
        wait_free();
        drive(MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_free();
        drive(MD_DIV,   32'h8000_0000, 32'd3);
        wait_free();
        drive(MD_RSV6,  32'hCAFE_0000, 32'd1);
        drive(MD_RSV7,  32'hBEEF_0000, 32'd1);
        idle(2);

        // Reset during a DIV: cleared at once, nothing written later
        drive(MD_MTHI,  32'hAAAA_5555, 32'd0);
        drive(MD_MTLO,  32'h5555_AAAA, 32'd0);
        drive(MD_DIV,   32'd100,       32'd7);
        idle(3);
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        q.delete();
        m_hi = 32'd0;  m_lo = 32'd0;  m_free = 0;
        mon_hi = 32'd0; mon_lo = 32'd0; prev_busy = 1'b0; run_len = 0;
        #1 reset = 1'b1;
        idle(14);

        // Randomized traffic, including starts that land while busy
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       x = 32'h8000_0000;
                1:       x = 32'($urandom_range(0, 20));
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(1, 9));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) wait_free();
            else idle($urandom_range(0, 3));
            drive(op, x, y);
        end

        wait_free();
        idle(3);
        chk("drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult_div
`default_nettype wire
